// File: rtl/dp_pkg.sv
// Shared definitions for the dual-port buffer datapath and its control sequencer.
package dp_pkg;

  // Defaults shared with the dp instance so both ends agree on geometry.
  localparam int unsigned DpDw    = 8;
  localparam int unsigned DpDepth = 8;

  // Sequencer states.
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StClr   = 3'd1,
    StFill  = 3'd2,
    StDrain = 3'd3,
    StDone  = 3'd4
  } dp_state_e;

  // A count that must reach DEPTH itself needs one bit more than an address.
  function automatic int unsigned dp_cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dp_seq_ctrl_if.sv
// Stream and dp-port bundle between the sequencer and its environment.
// master: the sequencer side; slave: the stream fabric plus the dp instance.
interface dp_seq_ctrl_if #(
  parameter int unsigned DW = 8
) ();

  // Upstream stream
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;

  // Downstream stream
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;

  // Batch completion
  logic          done;

  // dp port controls
  logic          dp_rst;
  logic          dp_wea;
  logic          dp_inca;
  logic [DW-1:0] dp_dina;
  logic          dp_web;
  logic          dp_incb;
  logic [DW-1:0] dp_outb;

  modport master (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    input  out_ready,
    output done,
    output dp_rst,
    output dp_wea,
    output dp_inca,
    output dp_dina,
    output dp_web,
    output dp_incb,
    input  dp_outb
  );

  modport slave (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    output out_ready,
    input  done,
    input  dp_rst,
    input  dp_wea,
    input  dp_inca,
    input  dp_dina,
    input  dp_web,
    input  dp_incb,
    output dp_outb
  );

endinterface

// File: rtl/dp_seq_ctrl.sv
// Batch sequencer for the dual-port buffer: fills DEPTH words through port A from
// an upstream stream, then drains them in order through port B to a downstream
// stream. All dp strobes are decoded from the registered state and the live
// handshakes, so a stalled consumer leaves the B address (and out_data) frozen.
module dp_seq_ctrl
  import dp_pkg::*;
#(
  parameter int unsigned DW    = DpDw,
  parameter int unsigned DEPTH = DpDepth,
  parameter int unsigned CW    = dp_cnt_width(DpDepth)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  dp_seq_ctrl_if.master     bus
);

  localparam logic [CW-1:0] CntZero = '0;
  localparam logic [CW-1:0] CntOne  = CW'(1);
  localparam logic [CW-1:0] CntLast = CW'(DEPTH - 1);
  localparam logic [CW-1:0] CntFull = CW'(DEPTH);

  dp_state_e     state_q, state_d;
  logic [CW-1:0] count_q, count_d;

  // Word-wide views of the data paths; the dp side is a pure pass-through.
  logic [DW-1:0] in_word;
  logic [DW-1:0] rd_word;

  assign in_word      = bus.in_data;
  assign rd_word      = bus.dp_outb;
  assign bus.dp_dina  = in_word;
  assign bus.out_data = rd_word;
  assign bus.dp_web   = 1'b0;

  // State and batch count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      count_q <= CntZero;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next state: abort overrides everything, including a start in IDLE.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (abort) begin
      state_d = StIdle;
      count_d = CntZero;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StClr;
          end
        end
        StClr: begin
          count_d = CntZero;
          state_d = StFill;
        end
        StFill: begin
          // in_ready is unconditionally high here, so in_valid alone is the handshake.
          if (bus.in_valid) begin
            if (count_q == CntLast) begin
              count_d = CntFull;
              state_d = StDrain;
            end else begin
              count_d = count_q + CntOne;
            end
          end
        end
        StDrain: begin
          // out_valid is unconditionally high here, so out_ready alone is the handshake.
          if (bus.out_ready) begin
            count_d = count_q - CntOne;
            if (count_q == CntOne) begin
              state_d = StDone;
            end
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
          count_d = CntZero;
        end
      endcase
    end
  end

  // Outputs: strobes decoded from state and handshakes, all forced low under abort.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.done      = 1'b0;
    bus.dp_rst    = 1'b0;
    bus.dp_wea    = 1'b0;
    bus.dp_inca   = 1'b0;
    bus.dp_incb   = 1'b0;
    if (!abort) begin
      case (state_q)
        StClr: begin
          bus.dp_rst = 1'b1;
        end
        StFill: begin
          bus.in_ready = 1'b1;
          bus.dp_wea   = bus.in_valid;
          bus.dp_inca  = bus.in_valid;
        end
        StDrain: begin
          bus.out_valid = 1'b1;
          bus.dp_incb   = bus.out_ready;
        end
        StDone: begin
          bus.done = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Invariants that keep the dp address counters within one batch.
  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count_q <= CntFull);
  a_fill_bound: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StFill) |-> (count_q < CntFull));
  a_drain_nonzero: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StDrain) |-> (count_q != CntZero));

endmodule

// File: tb/tb_dp_seq_ctrl.sv
// Scoreboard bench for dp_seq_ctrl with a behavioural dual-port buffer on the dp side.
module tb_dp_seq_ctrl;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 4;
  localparam int unsigned AW    = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;

  dp_seq_ctrl_if #(.DW(DW)) bus ();

  dp_seq_ctrl #(
    .DW   (DW),
    .DEPTH(DEPTH),
    .CW   (CW)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Behavioural dp: synchronous write on A, asynchronous read on B, wrapping counters.
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] addr_a = '0;
  logic [AW-1:0] addr_b = '0;

  always @(posedge clk) begin
    if (bus.dp_rst) begin
      addr_a <= '0;
      addr_b <= '0;
    end else begin
      if (bus.dp_wea)  mem[addr_a] <= bus.dp_dina;
      if (bus.dp_inca) addr_a <= addr_a + 1'b1;
      if (bus.dp_incb) addr_b <= addr_b + 1'b1;
    end
  end
  assign bus.dp_outb = mem[addr_b];

  int n_checks  = 0;
  int n_errors  = 0;
  int cyc       = 0;
  int n_out     = 0;
  int wr_cnt    = 0;
  int rst_cnt   = 0;
  int done_cnt  = 0;
  int first_wr  = -1;
  int last_wr   = -1;
  int last_xfer = -100;
  logic [DW-1:0] exp_q[$];

  function automatic void check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  // Monitor: samples 1 time unit after the falling edge, pops the scoreboard on transfers.
  always begin
    @(negedge clk);
    #1;
    cyc++;
    if (rst_n) begin
      check("web_tied_low", int'(bus.dp_web), 0);
      if (bus.dp_wea || bus.dp_inca) check("wea_inca_paired", int'(bus.dp_wea), int'(bus.dp_inca));
      if (bus.dp_wea) begin
        check("wea_needs_valid", int'(bus.in_valid), 1);
        check("dina_follows_in", int'(bus.dp_dina), int'(bus.in_data));
        wr_cnt++;
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
      end
      if (abort) begin
        check("abort_quiet", int'({bus.in_ready, bus.out_valid, bus.dp_rst, bus.dp_wea,
                                   bus.dp_incb, bus.done}), 0);
      end
      if (bus.dp_rst) rst_cnt++;
      if (bus.out_valid && bus.out_ready) begin
        check("incb_on_xfer", int'(bus.dp_incb), 1);
        if (exp_q.size() == 0) check("unexpected_word", int'(bus.out_data), -1);
        else check("out_data", int'(bus.out_data), int'(exp_q.pop_front()));
        n_out++;
        last_xfer = cyc;
      end else if (bus.out_valid) begin
        check("stall_incb_low", int'(bus.dp_incb), 0);
        if (exp_q.size() != 0) check("stall_hold", int'(bus.out_data), int'(exp_q[0]));
      end
      if (bus.done) begin
        done_cnt++;
        check("done_after_last", cyc, last_xfer + 1);
      end
    end
  end

  task automatic push_batch(input int base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(DW'(base + i));
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("clr_pulse", int'(bus.dp_rst), 1);
    check("ready_low_in_clr", int'(bus.in_ready), 0);
  endtask

  task automatic run_fill(input int base, input int n_words, input bit gaps,
                          input bit poke_start, input bit chk_lat);
    int idx = 0;
    int c = 0;
    bit ph = 1'b1;
    while (idx < n_words && c < 200) begin
      @(negedge clk);
      bus.in_valid = gaps ? ph : 1'b1;
      bus.in_data  = DW'(base + idx);
      ph = ~ph;
      if (poke_start) start = (c == 3);
      #1;
      if (chk_lat && c == 0) check("start_to_ready", int'(bus.in_ready), 1);
      if (bus.in_valid && bus.in_ready) idx++;
      c++;
    end
    start = 1'b0;
    check("fill_complete", idx, n_words);
  endtask

  task automatic run_drain(input int n_expect, input int stall_at, input int stall_len,
                           input int abort_at, input bit chk_lat);
    int n0 = n_out;
    int c = 0;
    int stalled = 0;
    bit fin = 1'b0;
    bus.out_ready = 1'b1;
    while (!fin && c < 200) begin
      @(negedge clk);
      if (c == 0) bus.in_valid = 1'b0;
      if (abort_at > 0 && n_out - n0 == abort_at) begin
        abort = 1'b1;
        fin = 1'b1;
      end else if (n_out - n0 == n_expect) begin
        fin = 1'b1;
      end else if (stall_at > 0 && n_out - n0 == stall_at && stalled < stall_len) begin
        bus.out_ready = 1'b0;
        stalled++;
      end else begin
        bus.out_ready = 1'b1;
      end
      #1;
      if (chk_lat && c == 0) check("accept_to_valid", int'(bus.out_valid), 1);
      c++;
    end
    check("drain_count", n_out - n0, (abort_at > 0) ? abort_at : n_expect);
    if (stall_at > 0) check("stall_cycles", stalled, stall_len);
    if (abort) begin
      @(negedge clk);
      abort = 1'b0;
      #1;
      check("abort_to_idle", int'({bus.in_ready, bus.out_valid}), 0);
    end
  endtask

  task automatic expect_done(input int exp, input int d0);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("done_pulses", done_cnt - d0, exp);
  endtask

  task automatic full_batch(input int base, input bit gaps, input bit poke_start,
                            input int stall_at, input bit chk_lat);
    int d0 = done_cnt;
    int w0 = wr_cnt;
    int r0 = rst_cnt;
    first_wr = -1;
    push_batch(base, DEPTH);
    pulse_start();
    run_fill(base, DEPTH, gaps, poke_start, chk_lat);
    run_drain(DEPTH, stall_at, 3, 0, chk_lat);
    expect_done(1, d0);
    check("write_count", wr_cnt - w0, DEPTH);
    check("clr_once", rst_cnt - r0, 1);
    check("wea_span", last_wr - first_wr, gaps ? 2 * (DEPTH - 1) : DEPTH - 1);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int w0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset, then idle with no start.
    repeat (2) @(negedge clk);
    #1;
    check("reset_quiet", int'({bus.in_ready, bus.out_valid, bus.done, bus.dp_rst,
                               bus.dp_wea, bus.dp_inca, bus.dp_incb}), 0);
    check("reset_out_passthru", int'(bus.out_data), int'(bus.dp_outb));
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check("idle_quiet", int'({bus.in_ready, bus.out_valid, bus.done, bus.dp_rst,
                                bus.dp_wea, bus.dp_inca, bus.dp_incb}), 0);
    end

    // Full batch back-to-back with latency checks.
    full_batch(1, 1'b0, 1'b0, 0, 1'b1);

    // Upstream gaps, with a stray start during FILL that must be ignored.
    full_batch(41, 1'b1, 1'b1, 0, 1'b0);

    // Downstream backpressure after the third word.
    full_batch(1, 1'b0, 1'b0, 3, 1'b0);

    // Abort mid-DRAIN after 4 words, then a fresh batch must re-clear dp.
    d0 = done_cnt;
    push_batch(21, 4);
    pulse_start();
    run_fill(21, DEPTH, 1'b0, 1'b0, 1'b0);
    run_drain(DEPTH, 0, 0, 4, 1'b0);
    expect_done(0, d0);
    check("abort_queue_empty", exp_q.size(), 0);
    full_batch(11, 1'b0, 1'b0, 0, 1'b0);

    // start and abort together in IDLE: stay idle.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    #1;
    check("start_abort_no_clr", int'(bus.dp_rst), 0);
    @(negedge clk);
    #1;
    check("start_abort_no_fill", int'(bus.in_ready), 0);

    // Asynchronous reset mid-FILL after 5 writes.
    w0 = wr_cnt;
    pulse_start();
    run_fill(51, 5, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_outputs", int'({bus.in_ready, bus.dp_wea, bus.dp_inca, bus.out_valid,
                                     bus.dp_rst, bus.done}), 0);
    check("partial_writes", wr_cnt - w0, 5);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    full_batch(31, 1'b0, 1'b0, 0, 1'b0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
